wb_sram_bridge: RTL
===================

# wb_sram_bridge

Wishbone B4 slave that terminates one slave port of the team's Wishbone interconnects and drives a single-port synchronous SRAM with one-cycle read latency. It supports classic cycles and registered-feedback bursts (constant, linear, wrap-4/8/16) at one beat per cycle, and returns ERR for addresses outside its window. It sits directly downstream of an interconnect slave port (s0/s1), with the interconnect's address window matching BASE_ADDR and the memory size.

## Interface
- WB_ADDR_WIDTH, 32, Wishbone byte-address width.
- WB_DATA_WIDTH, 32, Wishbone data width; power of two, at least 8.
- MEM_ADDR_WIDTH, 10, SRAM word-address width; memory spans 2^MEM_ADDR_WIDTH words.
- BASE_ADDR, 'h0, byte base address of the window; aligned to the window size.
- clk  input  1  single clock; all state on the rising edge.
- rstn  input  1  asynchronous, active-low reset.
- s  wb_if.slave  —  Wishbone port (ADR, CTI, BTE, DAT_W, DAT_R, CYC, ERR, SEL, STB, ACK, WE).
- sram_en  output  1  SRAM access enable.
- sram_we  output  1  write enable; valid only with sram_en.
- sram_addr  output  MEM_ADDR_WIDTH  word address.
- sram_be  output  WB_DATA_WIDTH/8  byte enables.
- sram_wdata  output  WB_DATA_WIDTH  write data.
- sram_rdata  input  WB_DATA_WIDTH  read data, valid the cycle after a read; held until the next read.

## Operation
- Offset decode: off = ADR - BASE_ADDR.
  - In range iff ADR >= BASE_ADDR and off < 2^MEM_ADDR_WIDTH * WB_DATA_WIDTH/8.
  - word = off >> log2(WB_DATA_WIDTH/8).
- States: IDLE, ACTIVE, ERROR. Registers: state, cur_addr (word being acknowledged), ack_q, err_q.
- Outputs are qualified:
  - ACK = ack_q & CYC & STB.
  - ERR = err_q & CYC & STB.
  - DAT_R = sram_rdata when ACK, else 0.
- IDLE, on CYC&STB:
  - Out of range: err_q<=1 and go to ERROR. No SRAM access.
  - In range: cur_addr<=word, ack_q<=1, go to ACTIVE. If !WE, issue the read this cycle (sram_en=1, sram_addr=word).
- ERROR: ERR is high for one cycle. err_q<=0, go to IDLE.
- ACTIVE with ACK=1 (beat completes):
  - Write beat: sram_en=1, sram_we=1, sram_addr=cur_addr, sram_be=SEL, sram_wdata=DAT_W.
  - Read beat: DAT_R = sram_rdata.
  - Continue only if CTI==001 or CTI==010. Then cur_addr<=next, ack_q stays 1, and a read burst issues the read of next this cycle.
  - Otherwise (000, 111, reserved 011–110): ack_q<=0 and go to IDLE.
- next address:
  - CTI 001: next = cur_addr.
  - CTI 010, BTE 00: next = cur_addr+1 modulo 2^MEM_ADDR_WIDTH (wraps inside the memory, never ERR).
  - BTE 01/10/11: increment only the low 2/3/4 bits; upper bits held.
- ACTIVE, ack_q=1, CYC&!STB (master wait state): no ACK, no write, cur_addr holds. A read burst re-issues the read of cur_addr so rdata stays valid.
- ACTIVE, CYC=0 (abort): ack_q<=0, go to IDLE. No SRAM write that cycle.
- WE is constant within a burst, so reads and writes never contend for the SRAM.
- sram_en/sram_we are 0 whenever rstn=0 or no access is defined above.

## Timing
- Reset (asynchronous, immediate) values:
  - state=IDLE, ack_q=0, err_q=0, cur_addr=0.
  - ACK=0, ERR=0, DAT_R=0, sram_en=0, sram_we=0, sram_addr=0, sram_be=0, sram_wdata=0.
- Classic read or write: STB sampled at cycle 0, ACK at cycle 1, next cycle can be sampled at cycle 2 (1 beat per 2 cycles).
- Burst: first ACK at cycle 1, then one ACK per cycle while STB is high. The beat tagged CTI=111 is acked and is the last.
- Write data is committed to the SRAM in the ACK cycle. Read data is launched from the SRAM the cycle before ACK.
- Error: ERR at cycle 1 for exactly one cycle. ACK never asserts together with ERR.
- ACK and ERR fall combinationally if the master drops STB or CYC.
- Reset asserted mid-burst: outputs go to reset values in the same cycle. The in-flight beat is not written.

## Test plan
- Classic write ADR=BASE+0x10, DAT_W=0xDEADBEEF, SEL=0xF → ACK at cycle 1, sram_we=1, sram_addr=4. Then classic read of the same address → ACK at cycle 1, DAT_R=0xDEADBEEF.
- Write SEL=0x2, DAT_W=0x0000AB00 to the same word → sram_be=0x2. Readback → 0xDEADABEF.
- Read burst CTI=010, BTE=01 from word 6, 4 beats, last beat CTI=111 → 4 consecutive ACKs for words 6,7,4,5, then IDLE.
- Linear write burst of 8 beats from word 0x3FE with STB low for 2 cycles before beat 3:
  - No ACK or write during the gap.
  - Writes go to words 0x3FE,0x3FF,0x000…0x005.
- Classic read at ADR=BASE+4*1024 → one ERR cycle, ACK=0, sram_en never asserted.
- rstn pulsed low during beat 3 of a write burst → ACK, ERR and sram_we go to 0 that cycle and no write occurs. After release, a classic read returns stored data at cycle 1.

Source files
------------

// File: rtl/wb_sram_bridge_if.sv
`default_nettype none
// ============================================================================
// Module : wb_if
// Wishbone B4 bus bundle (classic and registered-feedback burst signals).
// Rev    : 1.0
// ============================================================================
interface wb_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0]   adr;
  logic [2:0]              cti;
  logic [1:0]              bte;
  logic [DATA_WIDTH-1:0]   dat_w;
  logic [DATA_WIDTH-1:0]   dat_r;
  logic [DATA_WIDTH/8-1:0] sel;
  logic                    cyc;
  logic                    stb;
  logic                    we;
  logic                    ack;
  logic                    err;

  modport master (
    output adr, cti, bte, dat_w, sel, cyc, stb, we,
    input  dat_r, ack, err
  );

  modport slave (
    input  adr, cti, bte, dat_w, sel, cyc, stb, we,
    output dat_r, ack, err
  );
endinterface
`default_nettype wire

// File: rtl/wb_sram_bridge.sv
`default_nettype none
// ============================================================================
// Module : wb_sram_bridge
// Wishbone B4 slave onto a one-cycle-latency synchronous SRAM, with bursts.
// Rev    : 1.0
// ============================================================================
module wb_sram_bridge #(
  parameter int                       WB_ADDR_WIDTH  = 32,
  parameter int                       WB_DATA_WIDTH  = 32,
  parameter int                       MEM_ADDR_WIDTH = 10,
  parameter logic [WB_ADDR_WIDTH-1:0] BASE_ADDR      = '0
) (
  input  wire logic                       clk,
  input  wire logic                       rstn,
  wb_if.slave                             s,
  output logic                            sram_en,
  output logic                            sram_we,
  output logic [MEM_ADDR_WIDTH-1:0]       sram_addr,
  output logic [WB_DATA_WIDTH/8-1:0]      sram_be,
  output logic [WB_DATA_WIDTH-1:0]        sram_wdata,
  input  wire logic [WB_DATA_WIDTH-1:0]   sram_rdata
);

  localparam int c_lsb      = $clog2(WB_DATA_WIDTH / 8);
  localparam int c_win_bits = MEM_ADDR_WIDTH + c_lsb;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_ERROR  = 2'd2
  } state_t;

  state_t                    r_state;
  logic [MEM_ADDR_WIDTH-1:0] r_cur_addr;
  logic                      r_ack_q;
  logic                      r_err_q;

  state_t                    w_state_nxt;
  logic [MEM_ADDR_WIDTH-1:0] w_cur_addr_nxt;
  logic                      w_ack_q_nxt;
  logic                      w_err_q_nxt;

  logic [WB_ADDR_WIDTH-1:0]  w_off;
  logic                      w_in_range;
  logic [MEM_ADDR_WIDTH-1:0] w_word;
  logic [MEM_ADDR_WIDTH-1:0] w_wrap_mask;
  logic [MEM_ADDR_WIDTH-1:0] w_next_addr;
  logic                      w_ack;
  logic                      w_continue;

  // Window check without forming the window size, which can overflow the address width.
  assign w_off      = s.adr - BASE_ADDR;
  assign w_in_range = (s.adr >= BASE_ADDR) && ((w_off >> c_win_bits) == '0);
  assign w_word     = w_off[c_lsb +: MEM_ADDR_WIDTH];

  always_comb begin
    case (s.bte)
      2'b01:   w_wrap_mask = MEM_ADDR_WIDTH'(4'h3);
      2'b10:   w_wrap_mask = MEM_ADDR_WIDTH'(4'h7);
      2'b11:   w_wrap_mask = MEM_ADDR_WIDTH'(4'hF);
      default: w_wrap_mask = '1;
    endcase
  end

  // Wrapping bursts only advance the masked low bits; linear wraps at the memory top.
  assign w_next_addr = (s.cti == 3'b001) ? r_cur_addr
                     : ((r_cur_addr & ~w_wrap_mask) |
                        ((r_cur_addr + MEM_ADDR_WIDTH'(1)) & w_wrap_mask));
  assign w_continue  = (s.cti == 3'b001) || (s.cti == 3'b010);

  assign w_ack   = r_ack_q & s.cyc & s.stb;
  assign s.ack   = w_ack;
  assign s.err   = r_err_q & s.cyc & s.stb;
  assign s.dat_r = w_ack ? sram_rdata : '0;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state    <= ST_IDLE;
      r_cur_addr <= '0;
      r_ack_q    <= 1'b0;
      r_err_q    <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_cur_addr <= w_cur_addr_nxt;
      r_ack_q    <= w_ack_q_nxt;
      r_err_q    <= w_err_q_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_cur_addr_nxt = r_cur_addr;
    w_ack_q_nxt    = r_ack_q;
    w_err_q_nxt    = r_err_q;
    sram_en        = 1'b0;
    sram_we        = 1'b0;
    sram_addr      = '0;
    sram_be        = '0;
    sram_wdata     = '0;

    case (r_state)
      ST_IDLE: begin
        if (s.cyc && s.stb) begin
          if (!w_in_range) begin
            w_err_q_nxt = 1'b1;
            w_state_nxt = ST_ERROR;
          end else begin
            w_cur_addr_nxt = w_word;
            w_ack_q_nxt    = 1'b1;
            w_state_nxt    = ST_ACTIVE;
            if (!s.we) begin
              sram_en   = 1'b1;
              sram_addr = w_word;
            end
          end
        end
      end

      ST_ERROR: begin
        w_err_q_nxt = 1'b0;
        w_state_nxt = ST_IDLE;
      end

      ST_ACTIVE: begin
        if (!s.cyc) begin
          w_ack_q_nxt = 1'b0;
          w_state_nxt = ST_IDLE;
        end else if (w_ack) begin
          if (s.we) begin
            sram_en    = 1'b1;
            sram_we    = 1'b1;
            sram_addr  = r_cur_addr;
            sram_be    = s.sel;
            sram_wdata = s.dat_w;
          end
          if (w_continue) begin
            w_cur_addr_nxt = w_next_addr;
            if (!s.we) begin
              sram_en   = 1'b1;
              sram_addr = w_next_addr;
            end
          end else begin
            w_ack_q_nxt = 1'b0;
            w_state_nxt = ST_IDLE;
          end
        end else if (!s.we) begin
          // Master wait state: keep the SRAM output pointing at the pending beat.
          sram_en   = 1'b1;
          sram_addr = r_cur_addr;
        end
      end

      default: begin
        w_ack_q_nxt = 1'b0;
        w_err_q_nxt = 1'b0;
        w_state_nxt = ST_IDLE;
      end
    endcase

    if (!rstn) begin
      sram_en    = 1'b0;
      sram_we    = 1'b0;
      sram_addr  = '0;
      sram_be    = '0;
      sram_wdata = '0;
    end
  end

endmodule
`default_nettype wire
